add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq_if.sv | 40 ++++
 rtl/add_seq.sv | 136 +++++++++++++
 tb/tb_add_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_if.sv
// Request/response bundle for add_seq: two requesters share one slice-serial adder,
// one response channel returns the result tagged with the owner id.
interface add_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/add_seq.sv
// Time-shared SLICE-bit ripple adder/subtractor serving two round-robin requesters;
// one WIDTH-bit operation takes WIDTH/SLICE cycles, carry held between slices.
module add_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  add_seq_if.slave  bus
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = SLICE + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             id_q;
  logic             cout_q;
  logic             ovf_q;
  logic             valid_q;
  logic [CW-1:0]    cnt_q;

  logic             grant1_c;
  logic             accept_c;
  logic             last_c;
  logic             ready0_c;
  logic             ready1_c;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   slice_res;

  // Pointer only matters when both requesters are valid.
  always_comb begin
    grant1_c = bus.req1_valid && (!bus.req0_valid || rr_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    ready0_c  = 1'b0;
    ready1_c  = 1'b0;
    last_c    = (cnt_q == LAST);
    unique case (state)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          accept_c  = 1'b1;
          ready0_c  = !grant1_c;
          ready1_c  = grant1_c;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // b_q already holds b' (inverted for subtract), so the slice is a plain add.
  always_comb begin
    a_sl      = a_q[32'(cnt_q) * SLICE +: SLICE];
    b_sl      = b_q[32'(cnt_q) * SLICE +: SLICE];
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + SW'(carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= (state_nxt == DONE);
      if (accept_c) begin
        rr_ptr <= !grant1_c;
        id_q   <= grant1_c;
        cnt_q  <= '0;
        if (grant1_c) begin
          a_q     <= bus.req1_a;
          b_q     <= bus.req1_sub ? ~bus.req1_b : bus.req1_b;
          carry_q <= bus.req1_sub;
        end else begin
          a_q     <= bus.req0_a;
          b_q     <= bus.req0_sub ? ~bus.req0_b : bus.req0_b;
          carry_q <= bus.req0_sub;
        end
      end else if (state == RUN) begin
        sum_q[32'(cnt_q) * SLICE +: SLICE] <= slice_res[SLICE-1:0];
        carry_q <= slice_res[SLICE];
        cnt_q   <= cnt_q + CW'(1);
        if (last_c) begin
          cout_q <= slice_res[SLICE];
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_res[SLICE-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed vector table, multi-cycle corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_add_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic ptr;

  add_seq_if #(.WIDTH(32)) bus ();

  add_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic, returns {cout, ovf, sum}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    longint ua, ub, sa, sb, sr;
    logic [31:0] s;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      s  = a + b;
      c  = (ua + ub) >= 64'sh1_0000_0000;
      sr = sa + sb;
    end else begin
      s  = a - b;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    return {c, v, s};
  endfunction

  task automatic drop_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_sub = 1'b0;
    bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_sub = 1'b1;
  endtask

  task automatic apply_reset();
    drop_reqs();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    ptr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; runs one full transaction.
  task automatic run_op(input logic [1:0] mask,
                        input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                        input logic exp_id, input logic [31:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int stall);
    int edges;
    bus.req0_valid = mask[0]; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sub = s0;
    bus.req1_valid = mask[1]; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = s1;
    #1;
    check1("grant_ready0", bus.req0_ready, !exp_id);
    check1("grant_ready1", bus.req1_ready, exp_id);
    if (!(bus.req0_ready || bus.req1_ready)) begin
      drop_reqs();
      @(negedge clk);
      return;
    end
    ptr = !exp_id;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    drop_reqs();
    while (!bus.rsp_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_int("latency", edges, 4);
    check32("sum", bus.rsp_sum, exp_sum);
    check1("cout", bus.rsp_cout, exp_cout);
    check1("ovf", bus.rsp_ovf, exp_ovf);
    check1("id", bus.rsp_id, exp_id);
    if (stall > 0) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check1("stall_valid", bus.rsp_valid, 1'b1);
      check32("stall_sum", bus.rsp_sum, exp_sum);
      check1("stall_id", bus.rsp_id, exp_id);
      check1("stall_no_ready", bus.req0_ready | bus.req1_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("handshake_idle", bus.rsp_valid, 1'b0);
    if (stall > 0) check1("idle_regrant", bus.req0_ready | bus.req1_ready, 1'b1);
    drop_reqs();
    bus.rsp_ready = 1'b0;
  endtask

  vec_t        vecs [8];
  logic [33:0] m;
  logic [1:0]  mask;
  logic        eid;
  logic        g;
  logic [31:0] ra0, rb0, ra1, rb1;
  logic        rs0, rs1;
  logic        gq [$];
  int          ng, nr, both;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    ptr    = 1'b0;
    rst_n  = 1'b0;
    drop_reqs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b0;

    vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    // Reset state, with both requesters valid during reset.
    @(negedge clk);
    check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check1("rst_ready0", bus.req0_ready, 1'b0);
    check1("rst_ready1", bus.req1_ready, 1'b0);
    check32("rst_sum", bus.rsp_sum, 32'h0);
    check1("rst_cout", bus.rsp_cout, 1'b0);
    check1("rst_ovf", bus.rsp_ovf, 1'b0);
    check1("rst_id", bus.rsp_id, 1'b0);
    apply_reset();

    // Directed vector table, one requester at a time.
    for (int i = 0; i < 8; i++) begin
      mask = vecs[i].id ? 2'b10 : 2'b01;
      run_op(mask, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].id, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 0);
    end

    // Response held off for 10 cycles in DONE.
    run_op(2'b01, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 1'b0,
           1'b0, 32'h0000_0100, 1'b0, 1'b0, 10);

    // Reset pulsed during the second RUN cycle.
    bus.req0_valid = 1'b1; bus.req0_a = 32'h1111_1111; bus.req0_b = 32'h2222_2222;
    bus.req0_sub = 1'b0;
    #1;
    check1("rr_run_ready", bus.req0_ready, 1'b1);
    @(posedge clk);
    ptr = 1'b1;
    @(negedge clk);
    drop_reqs();
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    ptr   = 1'b0;
    #1;
    check1("mid_rst_valid", bus.rsp_valid, 1'b0);
    check1("mid_rst_ready0", bus.req0_ready, 1'b0);
    check1("mid_rst_ready1", bus.req1_ready, 1'b0);
    check32("mid_rst_sum", bus.rsp_sum, 32'h0);
    check1("mid_rst_cout", bus.rsp_cout, 1'b0);
    check1("mid_rst_ovf", bus.rsp_ovf, 1'b0);
    check1("mid_rst_id", bus.rsp_id, 1'b0);
    @(negedge clk);
    drop_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("post_rst_quiet", bus.rsp_valid, 1'b0);
    end
    m = model(32'h0000_0003, 32'h0000_0004, 1'b1);
    run_op(2'b11, 32'h0000_0003, 32'h0000_0004, 1'b1, 32'h9, 32'h9, 1'b0,
           1'b0, m[31:0], m[33], m[32], 0);

    // Both requesters valid continuously after reset: grants must alternate.
    apply_reset();
    ra0 = 32'd10;  rb0 = 32'd3; rs0 = 1'b0;
    ra1 = 32'd100; rb1 = 32'd1; rs1 = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = ra0; bus.req0_b = rb0; bus.req0_sub = rs0;
    bus.req1_valid = 1'b1; bus.req1_a = ra1; bus.req1_b = rb1; bus.req1_sub = rs1;
    bus.rsp_ready = 1'b1;
    ng = 0; nr = 0; both = 0;
    for (int cyc = 0; cyc < 80 && nr < 4; cyc++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        check_int("alt_grant", int'(g), ng % 2);
        ng++;
        gq.push_back(g);
      end
      if (bus.rsp_valid) begin
        eid = (gq.size() > 0) ? gq.pop_front() : 1'b0;
        m = eid ? model(ra1, rb1, rs1) : model(ra0, rb0, rs0);
        check1("alt_rsp_id", bus.rsp_id, eid);
        check32("alt_rsp_sum", bus.rsp_sum, m[31:0]);
        nr++;
        if (nr == 4) drop_reqs();
      end
      @(negedge clk);
    end
    check_int("alt_both_ready", both, 0);
    check_int("alt_rsp_count", nr, 4);
    drop_reqs();
    bus.rsp_ready = 1'b0;
    ptr = 1'b0;
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      ra0 = $urandom; rb0 = $urandom; rs0 = 1'($urandom_range(0, 1));
      ra1 = $urandom; rb1 = $urandom; rs1 = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb0 = ra0;
      eid = (mask == 2'b01) ? 1'b0 : (mask == 2'b10) ? 1'b1 : ptr;
      m = eid ? model(ra1, rb1, rs1) : model(ra0, rb0, rs0);
      run_op(mask, ra0, rb0, rs0, ra1, rb1, rs1, eid, m[31:0], m[33], m[32],
             $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
